// File: rtl/monopix_readout_responder.sv
// Chip-side readout responder: buffers hit words, raises token while
// any are pending, and serializes one word MSB first per READ rise.
module monopix_readout_responder #(
  parameter int DEPTH = 4,
  parameter int DW    = 27,
  parameter int CNT_W = 8
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             hit_valid,
  input  logic [DW-1:0]    hit_data,
  output logic             hit_ready,
  input  logic             read,
  input  logic             freeze,
  output logic             token,
  output logic             data_out,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(DW);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic [DW-1:0]   sreg;
  logic [BW-1:0]   bit_cnt;

  logic read_m;
  logic read_s;
  logic read_q;
  logic freeze_m;
  logic freeze_s;

  logic full;
  logic push;
  logic pop;
  logic drop;
  logic read_rise;

  assign full      = (count == (AW+1)'(DEPTH));
  assign hit_ready = ~full & ~freeze_s;
  assign push      = hit_valid & hit_ready;
  assign drop      = hit_valid & ~hit_ready;
  assign read_rise = read_s & ~read_q;
  assign pop       = (state == IDLE) & read_rise & (count != '0);

  // Occupancy after this edge; push+pop cancel out.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Two-flop synchronisers for the asynchronous READ and FREEZE lines.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      read_m   <= 1'b0;
      read_s   <= 1'b0;
      read_q   <= 1'b0;
      freeze_m <= 1'b0;
      freeze_s <= 1'b0;
    end else begin
      read_m   <= read;
      read_s   <= read_m;
      read_q   <= read_s;
      freeze_m <= freeze;
      freeze_s <= freeze_m;
    end
  end

  // Hit storage; contents are don't-care until written.
  always_ff @(posedge clk_out) begin
    if (push) mem[wr_ptr] <= hit_data;
  end

  // FIFO pointers, occupancy and registered token.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      token  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      token <= (count_next != '0);
    end
  end

  // Saturating count of hits refused while full or frozen.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Serializer: load on READ rise, then DW bits MSB first.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      data_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          busy     <= 1'b0;
          data_out <= 1'b0;
          if (pop) begin
            sreg     <= mem[rd_ptr];
            data_out <= mem[rd_ptr][DW-1];
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == BW'(DW-1)) begin
            busy     <= 1'b0;
            data_out <= 1'b0;
            state    <= IDLE;
          end else begin
            sreg     <= sreg << 1;
            data_out <= sreg[DW-2];
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
